// File: rtl/seq_restoring_divider_if.sv
// -----------------------------------------------------------------------------
// seq_restoring_divider_if
//   Host-side handshake bundle for the sequential restoring divider.
//   Groups the request (start + operands) and the result/status signals so the
//   host and the divider connect through one port each.
//
//   Parameter:
//     WIDTH        operand / result width
//   Signals:
//     start        host request, accepted only while the divider is idle
//     abort        (only with DIV_ABORT_EN) cancels a running division
//     dividend     numerator, sampled on the accepting edge
//     divisor      denominator, sampled on the accepting edge
//     busy         divider is calculating or presenting its result
//     done         one-cycle pulse, results valid
//     quotient     result, held until the next accepted start
//     remainder    result, held until the next accepted start
//     div_by_zero  set together with done when divisor was zero
//   Modports:
//     master       host side (drives request)
//     slave        divider side (drives results)
//   Configuration macro: DIV_ABORT_EN adds the abort signal.
// -----------------------------------------------------------------------------
interface seq_restoring_divider_if #(
  parameter int WIDTH = 8
);
  logic             start;
`ifdef DIV_ABORT_EN
  logic             abort;
`endif
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

`ifdef DIV_ABORT_EN
  modport master (
    output start, abort, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, abort, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
`else
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
`endif
endinterface

// File: rtl/seq_restoring_divider.sv
// -----------------------------------------------------------------------------
// seq_restoring_divider
//   Sequential unsigned restoring divider producing one quotient bit per clock,
//   MSB first. A three-state FSM (IDLE / CALC / DONE) drives a start/busy/done
//   handshake. Quotient, remainder and div_by_zero are held until the next
//   accepted start.
//
//   Parameter:
//     WIDTH   operand width; quotient and remainder are WIDTH bits each
//   Ports:
//     clk     single clock, rising edge
//     reset   synchronous, active-high; clears all state
//     bus     seq_restoring_divider_if.slave (start, [abort], dividend,
//             divisor in; busy, done, quotient, remainder, div_by_zero out)
//
//   Timing: a start accepted at edge E0 with a non-zero divisor gives done in
//   the cycle after the WIDTH-th following edge (WIDTH+1 edges counting E0);
//   a zero divisor gives done in the cycle right after E0.
//
//   Configuration macro: DIV_ABORT_EN
//     defined   : bus.abort cancels a running CALC (back to IDLE, no done,
//                 held results untouched). Ignored in IDLE and DONE; start
//                 wins over abort in IDLE.
//     undefined : no abort; only reset interrupts a calculation.
// -----------------------------------------------------------------------------
module seq_restoring_divider #(
  parameter int WIDTH = 8
) (
  input logic                    clk,
  input logic                    reset,
  seq_restoring_divider_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   rem_acc_q;
  logic [WIDTH-1:0]   q_acc_q;
  logic [WIDTH-1:0]   divisor_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   quotient_q;
  logic [WIDTH-1:0]   remainder_q;
  logic               div_by_zero_q;

  // One restoring step computed from the current accumulators.
  logic [WIDTH+1:0]   trial_s;
  logic               trial_neg_s;
  logic [WIDTH-1:0]   rem_step_d;
  logic [WIDTH-1:0]   q_step_d;
  logic               abort_s;

  // Restoring step: subtract divisor from the shifted partial remainder; keep
  // the difference only when it does not go negative.
  always_comb begin
    trial_s     = {1'b0, rem_acc_q, q_acc_q[WIDTH-1]} - {2'b00, divisor_q};
    // The extra top bit is the borrow: set means the trial went negative.
    trial_neg_s = trial_s[WIDTH+1];
    if (trial_neg_s) begin
      rem_step_d = {rem_acc_q[WIDTH-2:0], q_acc_q[WIDTH-1]};
      q_step_d   = {q_acc_q[WIDTH-2:0], 1'b0};
    end else begin
      rem_step_d = trial_s[WIDTH-1:0];
      q_step_d   = {q_acc_q[WIDTH-2:0], 1'b1};
    end
  end

  // Abort request; tied inactive when the feature is not built.
  always_comb begin
    abort_s = 1'b0;
`ifdef DIV_ABORT_EN
    abort_s = bus.abort;
`else
    abort_s = 1'b0;
`endif
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      rem_acc_q     <= {WIDTH{1'b0}};
      q_acc_q       <= {WIDTH{1'b0}};
      divisor_q     <= {WIDTH{1'b0}};
      cnt_q         <= {CNT_W{1'b0}};
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      quotient_q    <= {WIDTH{1'b0}};
      remainder_q   <= {WIDTH{1'b0}};
      div_by_zero_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          if (bus.start) begin
            div_by_zero_q <= 1'b0;
            divisor_q     <= bus.divisor;
            if (bus.divisor == {WIDTH{1'b0}}) begin
              // No iterations needed: report all-ones quotient immediately.
              state_q       <= ST_DONE;
              busy_q        <= 1'b1;
              done_q        <= 1'b1;
              quotient_q    <= {WIDTH{1'b1}};
              remainder_q   <= bus.dividend;
              div_by_zero_q <= 1'b1;
            end else begin
              state_q   <= ST_CALC;
              busy_q    <= 1'b1;
              rem_acc_q <= {WIDTH{1'b0}};
              q_acc_q   <= bus.dividend;
              cnt_q     <= CNT_W'(WIDTH);
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end

        ST_CALC: begin
          if (abort_s) begin
            // Cancel silently; previously published results stay untouched.
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end else begin
            rem_acc_q <= rem_step_d;
            q_acc_q   <= q_step_d;
            cnt_q     <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              // Last bit: publish this step's values directly.
              state_q     <= ST_DONE;
              done_q      <= 1'b1;
              quotient_q  <= q_step_d;
              remainder_q <= rem_step_d;
            end else begin
              state_q <= ST_CALC;
            end
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
module tb_seq_restoring_divider;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seq_restoring_divider_if #(.WIDTH(WIDTH)) bus ();
  seq_restoring_divider #(.WIDTH(WIDTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  // Reference model: plain arithmetic from the division rules.
  task automatic ref_div(input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] q, output logic [7:0] r, output logic dz);
    if (b == 8'd0) begin
      q = 8'hFF; r = a; dz = 1'b1;
    end else begin
      q = a / b; r = a % b; dz = 1'b0;
    end
  endtask

  // Start one operation and observe it until the divider is idle again.
  // Returns edges from accept (counted as 1) to done, busy cycles, done pulses.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       output int edges_to_done, output int busy_cycles, output int dones);
    int edges;
    bit seen;
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.dividend = 8'($urandom); bus.divisor = 8'($urandom);
    edges_to_done = -1; busy_cycles = 0; dones = 0; seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.busy) busy_cycles++;
      if (bus.done) begin
        dones++;
        if (!seen) edges_to_done = edges;
        seen = 1'b1;
      end
      if (seen && !bus.busy) break;
      @(posedge clk); edges++; @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.quotient !== 8'd0) begin errors++; $display("FAIL reset_quot got=%0d exp=0", bus.quotient); end
    checks++; if (bus.remainder !== 8'd0) begin errors++; $display("FAIL reset_rem got=%0d exp=0", bus.remainder); end
    checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dz got=%b exp=0", bus.div_by_zero); end
    reset = 1'b0;
  endtask

  task automatic test_basic;
    logic [7:0] av [4] = '{8'd200, 8'd255, 8'd5, 8'd0};
    logic [7:0] bv [4] = '{8'd7,   8'd1,   8'd9, 8'd3};
    logic [7:0] eq [4] = '{8'd28,  8'd255, 8'd0, 8'd0};
    logic [7:0] er [4] = '{8'd4,   8'd0,   8'd5, 8'd0};
    int e, bc, d;
    for (int k = 0; k < 4; k++) begin
      do_op(av[k], bv[k], e, bc, d);
      checks++; if (bus.quotient !== eq[k]) begin errors++; $display("FAIL basic_quot %0d/%0d got=%0d exp=%0d", av[k], bv[k], bus.quotient, eq[k]); end
      checks++; if (bus.remainder !== er[k]) begin errors++; $display("FAIL basic_rem %0d/%0d got=%0d exp=%0d", av[k], bv[k], bus.remainder, er[k]); end
      checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL basic_dz got=%b exp=0", bus.div_by_zero); end
      checks++; if (e !== WIDTH + 1) begin errors++; $display("FAIL basic_latency got=%0d exp=%0d", e, WIDTH + 1); end
      checks++; if (bc !== WIDTH + 1) begin errors++; $display("FAIL basic_busy_cycles got=%0d exp=%0d", bc, WIDTH + 1); end
      checks++; if (d !== 1) begin errors++; $display("FAIL basic_done_pulses got=%0d exp=1", d); end
    end
  endtask

  task automatic test_div_zero;
    int e, bc, d;
    do_op(8'd77, 8'd0, e, bc, d);
    checks++; if (bus.quotient !== 8'hFF) begin errors++; $display("FAIL dz_quot got=%0h exp=ff", bus.quotient); end
    checks++; if (bus.remainder !== 8'd77) begin errors++; $display("FAIL dz_rem got=%0d exp=77", bus.remainder); end
    checks++; if (bus.div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_flag got=%b exp=1", bus.div_by_zero); end
    checks++; if (e !== 1) begin errors++; $display("FAIL dz_latency got=%0d exp=1", e); end
    checks++; if (bc !== 1) begin errors++; $display("FAIL dz_busy_cycles got=%0d exp=1", bc); end
    do_op(8'd10, 8'd3, e, bc, d);
    checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL dz_clear got=%b exp=0", bus.div_by_zero); end
    checks++; if (bus.quotient !== 8'd3 || bus.remainder !== 8'd1) begin errors++; $display("FAIL dz_next got=%0d r %0d exp=3 r 1", bus.quotient, bus.remainder); end
  endtask

  task automatic test_ignore_start;
    int dones = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 8'd100; bus.divisor = 8'd3;
    @(posedge clk); @(negedge clk);
    for (int i = 0; i < 30; i++) begin
      if (bus.done) dones++;
      if (i == 2 || i == 3) begin
        bus.start = 1'b1; bus.dividend = 8'd9; bus.divisor = 8'd9;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); @(negedge clk);
    end
    checks++; if (dones !== 1) begin errors++; $display("FAIL ignore_done_pulses got=%0d exp=1", dones); end
    checks++; if (bus.quotient !== 8'd33 || bus.remainder !== 8'd1) begin errors++; $display("FAIL ignore_result got=%0d r %0d exp=33 r 1", bus.quotient, bus.remainder); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ignore_idle got=%b exp=0", bus.busy); end
  endtask

  task automatic test_reset_mid;
    int dones = 0;
    int e, bc, d;
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 8'd123; bus.divisor = 8'd5;
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL midreset_hs got busy=%b done=%b exp=0 0", bus.busy, bus.done); end
    checks++; if (bus.quotient !== 8'd0 || bus.remainder !== 8'd0 || bus.div_by_zero !== 1'b0) begin
      errors++; $display("FAIL midreset_out got=%0d r %0d dz %b exp=0 r 0 dz 0", bus.quotient, bus.remainder, bus.div_by_zero); end
    for (int i = 0; i < 12; i++) begin
      if (bus.done || bus.busy) dones++;
      @(posedge clk); @(negedge clk);
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL midreset_silent got=%0d exp=0", dones); end
    do_op(8'd50, 8'd6, e, bc, d);
    checks++; if (bus.quotient !== 8'd8 || bus.remainder !== 8'd2 || d !== 1) begin
      errors++; $display("FAIL midreset_after got=%0d r %0d dones %0d exp=8 r 2 dones 1", bus.quotient, bus.remainder, d); end
  endtask

  task automatic test_random;
    logic [7:0] a, b, q, r;
    logic dz;
    int e, bc, d, exp_e;
    for (int k = 0; k < 40; k++) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      ref_div(a, b, q, r, dz);
      exp_e = (b == 8'd0) ? 1 : WIDTH + 1;
      do_op(a, b, e, bc, d);
      checks++; if (bus.quotient !== q || bus.remainder !== r || bus.div_by_zero !== dz) begin
        errors++; $display("FAIL rand_result %0d/%0d got=%0d r %0d dz %b exp=%0d r %0d dz %b", a, b, bus.quotient, bus.remainder, bus.div_by_zero, q, r, dz); end
      checks++; if (e !== exp_e || d !== 1) begin
        errors++; $display("FAIL rand_timing %0d/%0d got=%0d edges %0d dones exp=%0d edges 1 dones", a, b, e, d, exp_e); end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] oa [4];
    logic [7:0] ob [4];
    logic [7:0] q, r;
    logic dz;
    int acc_idx = 0, done_idx = 0, idle_run = 0;
    bit prev_busy = 1'b0, started = 1'b0;
    for (int k = 0; k < 4; k++) begin
      oa[k] = 8'($urandom);
      ob[k] = (k == 2) ? 8'd0 : 8'($urandom_range(1, 255));
    end
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = oa[0]; bus.divisor = ob[0];
    for (int cyc = 0; cyc < 100 && done_idx < 4; cyc++) begin
      @(posedge clk); @(negedge clk);
      if (bus.done) begin
        ref_div(oa[done_idx], ob[done_idx], q, r, dz);
        checks++; if (bus.quotient !== q || bus.remainder !== r || bus.div_by_zero !== dz) begin
          errors++; $display("FAIL b2b_result op%0d got=%0d r %0d dz %b exp=%0d r %0d dz %b", done_idx, bus.quotient, bus.remainder, bus.div_by_zero, q, r, dz); end
        done_idx++;
      end
      if (bus.busy && !prev_busy) begin
        if (started) begin
          checks++; if (idle_run !== 1) begin errors++; $display("FAIL b2b_gap got=%0d exp=1", idle_run); end
        end
        started = 1'b1; idle_run = 0; acc_idx++;
        if (acc_idx < 4) begin
          bus.dividend = oa[acc_idx]; bus.divisor = ob[acc_idx];
        end else begin
          bus.start = 1'b0;
        end
      end else if (!bus.busy) begin
        idle_run++;
      end
      prev_busy = bus.busy;
    end
    bus.start = 1'b0;
    checks++; if (done_idx !== 4) begin errors++; $display("FAIL b2b_count got=%0d exp=4", done_idx); end
    repeat (3) @(posedge clk);
  endtask

`ifdef DIV_ABORT_EN
  task automatic test_abort;
    int e, bc, d, dones = 0;
    do_op(8'd200, 8'd7, e, bc, d);
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 8'd99; bus.divisor = 8'd4;
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    bus.abort = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.abort = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL abort_hs got busy=%b done=%b exp=0 0", bus.busy, bus.done); end
    for (int i = 0; i < 12; i++) begin
      if (bus.done) dones++;
      @(posedge clk); @(negedge clk);
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL abort_silent got=%0d exp=0", dones); end
    checks++; if (bus.quotient !== 8'd28 || bus.remainder !== 8'd4) begin errors++; $display("FAIL abort_held got=%0d r %0d exp=28 r 4", bus.quotient, bus.remainder); end
    bus.start = 1'b1; bus.abort = 1'b1; bus.dividend = 8'd20; bus.divisor = 8'd6;
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL abort_start_wins got=%b exp=1", bus.busy); end
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus.done) dones++;
      @(posedge clk); @(negedge clk);
    end
    checks++; if (dones !== 1 || bus.quotient !== 8'd3 || bus.remainder !== 8'd2) begin
      errors++; $display("FAIL abort_start_result got=%0d r %0d dones %0d exp=3 r 2 dones 1", bus.quotient, bus.remainder, dones); end
  endtask
`endif

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.dividend = 8'd0;
    bus.divisor = 8'd0;
`ifdef DIV_ABORT_EN
    bus.abort = 1'b0;
`endif
    test_reset();
    test_basic();
    test_div_zero();
    test_ignore_start();
    test_reset_mid();
    test_random();
    test_back_to_back();
`ifdef DIV_ABORT_EN
    test_abort();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
